apb_master: RTL

APB requester that converts a simple valid/ready command stream into single APB transfers and returns a one-cycle response. It drives the PSELx/PENABLE/PADDR/PWRITE/PWDATA side of a UART_APB (or GPIO) peripheral and samples PRDATA/PREADY. It serves as the bus-side counterpart to the peripheral slaves, used by the CPU-less test harness and the top-level integration. One transfer is outstanding at a time; there is no pipelining.

---
 rtl/apb_master.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/apb_master.sv
// apb_master: APB requester. Turns a valid/ready command stream into single
// APB transfers (one outstanding, no pipelining) and returns a one-cycle
// response strobe with read data.
//
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that
// see PREADY low for TIMEOUT_CYCLES cycles. The abort is reported with
// rsp_error=1. Without the macro, ACCESS waits indefinitely and rsp_error is
// tied to 0.
//
// Ports:
//   PCLK, PRESETn                     clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_write/cmd_addr/cmd_wdata      command payload
//   rsp_valid/rsp_rdata/rsp_error     response (rsp_valid is a one-cycle pulse)
//   PADDR/PWDATA/PWRITE/PSELx/PENABLE APB request side
//   PRDATA/PREADY                     APB completion side
module apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PWRITE,
  output logic              PSELx,
  output logic              PENABLE,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] wait_inc;
  logic       rsp_error_q, rsp_error_d;
  assign wait_inc  = wait_cnt_q + 8'd1;
  assign rsp_error = rsp_error_q;
`else
  assign rsp_error = 1'b0;
`endif

  // Select/enable/ready decode straight from the state register so that an
  // asynchronous reset drops PSELx/PENABLE immediately.
  assign cmd_ready = (state_q == IDLE);
  assign PSELx     = (state_q != IDLE);
  assign PENABLE   = (state_q == ACCESS);
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    rsp_error_d = rsp_error_q;
`endif
    case (state_q)
      IDLE: begin
        // Address/data/direction only move on acceptance and are held
        // afterwards, including through IDLE.
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          // Normal completion wins over a timeout on the same edge.
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          state_d     = IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_error_d = 1'b0;
        end else if (wait_inc == TO_LIM) begin
          // This wait cycle brings the counter to the limit: abort.
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_inc;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= '0;
      rsp_error_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      rsp_error_q <= rsp_error_d;
`endif
    end
  end

endmodule
